pkt_write_arbiter: RTL
======================

PKT_WRITE_ARBITER -- requirements
Module: pkt_write_arbiter

Interface
REQ-001 The module SHALL have one parameter: RR_INIT, default 1'b0, the port holding round-robin priority after reset (0 = p0, 1 = p1).
REQ-002 i_clk  input  1  the single clock; all logic SHALL be on its rising edge.
REQ-003 i_rst_n  input  1  reset, asynchronous and active-low.
REQ-004 iv_pkt_p0  input  134  port-0 packet word, stable while i_pkt_wr_p0 = 1 and not yet acked.
REQ-005 i_pkt_wr_p0  input  1  port-0 write request, held until acked.
REQ-006 iv_pkt_bufadd_p0  input  16  port-0 buffer line address, {bufid[8:0], line[6:0]}.
REQ-007 o_pkt_ack_p0  output  1  one-cycle pulse: port-0 word accepted.
REQ-008 iv_pkt_p1, i_pkt_wr_p1, iv_pkt_bufadd_p1, o_pkt_ack_p1 SHALL be port-1 copies of REQ-004..REQ-007.
REQ-009 ov_pkt  output  134  word to the shared packet buffer.
REQ-010 o_pkt_wr  output  1  packet buffer write strobe, one cycle per word.
REQ-011 ov_pkt_bufadd  output  16  packet buffer write address.
REQ-012 i_cnt_clear  input  1  synchronous clear of both statistics counters.
REQ-013 ov_wr_cnt_p0, ov_wr_cnt_p1  output  16 each  accepted-word counters, per port.
REQ-014 o_conflict_pulse  output  1  one-cycle pulse: both ports eligible in the same cycle.

Function
REQ-015 A port SHALL be eligible in cycle t when its i_pkt_wr is 1 and it was not granted in cycle t-1 (one-cycle blind window absorbing registered ack latency).
REQ-016 At most one port SHALL be granted per cycle; one eligible port wins outright; two eligible ports resolve by the round-robin pointer.
REQ-017 After a grant the pointer SHALL move to the non-granted port; with no grant the pointer SHALL hold.
REQ-018 A grant sampled at edge t SHALL produce, at edge t+1, o_pkt_wr = 1, ov_pkt/ov_pkt_bufadd = the granted port's sampled values, and that port's o_pkt_ack = 1 (latency 1 cycle).
REQ-019 o_pkt_wr and both acks SHALL be 0 in every cycle without a grant; o_pkt_ack_p0 and o_pkt_ack_p1 SHALL never be 1 together.
REQ-020 ov_pkt and ov_pkt_bufadd SHALL hold their last value when o_pkt_wr = 0.
REQ-021 Each port SHALL sustain at most one word per two cycles; with both ports continuously requesting, output SHALL alternate p0/p1 with o_pkt_wr = 1 every cycle.
REQ-022 o_conflict_pulse SHALL be 1 at edge t+1 when both ports were eligible at edge t.
REQ-023 ov_wr_cnt_pN SHALL increment by 1 on each o_pkt_ack_pN, wrapping 16'hFFFF -> 16'h0000.
REQ-024 i_cnt_clear SHALL zero both counters at the next edge; a simultaneous ack SHALL be lost (clear wins).
REQ-025 A request withdrawn before grant SHALL simply not be granted; no state other than the pointer SHALL be affected.
REQ-026 Bit 133:132 (word type) and the address SHALL pass unmodified; the block SHALL not inspect packet content.

Reset
REQ-027 While i_rst_n = 0: o_pkt_wr, o_pkt_ack_p0, o_pkt_ack_p1, o_conflict_pulse = 0; ov_pkt = 134'h0; ov_pkt_bufadd = 16'h0; counters = 0; pointer = RR_INIT; blind flags cleared.
REQ-028 Reset asserted mid-operation SHALL discard any pending grant; no write or ack SHALL appear in the cycle after reset release.

Verification
REQ-029 Single port: p0 requests bufadd 16'h0080, data D0, held -> o_pkt_wr + o_pkt_ack_p0 one cycle later, ov_pkt_bufadd = 16'h0080, next accept no earlier than 2 cycles later, ov_wr_cnt_p0 = 1.
REQ-030 Contention, RR_INIT = 0: both request continuously for 8 cycles -> grants p0,p1,p0,p1..., o_pkt_wr every cycle after the first, o_conflict_pulse on first cycle, each counter = 4.
REQ-031 Wrap: force 65535 acks on p1 then one more -> ov_wr_cnt_p1 = 16'h0000, p0 counter unchanged.
REQ-032 Clear collision: i_cnt_clear in same cycle as p0 ack with counter 5 -> counter = 0 next cycle.
REQ-033 Reset mid-burst: i_rst_n low while p1 granted -> all outputs 0 immediately, pointer = RR_INIT, no ack after release until a new request is sampled.
REQ-034 Idle: no requests for 100 cycles -> o_pkt_wr = 0, ov_pkt/ov_pkt_bufadd hold last values, pointer unchanged.

Source files
------------

// File: rtl/pkt_write_arbiter.sv
// Two-port round-robin write arbiter for a shared packet buffer.
// Outputs are registered one cycle after a grant, so a granted port is blind for one cycle.
module pkt_write_arbiter #(
    parameter logic RR_INIT = 1'b0
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic [133:0]   iv_pkt_p0,
    input  logic           i_pkt_wr_p0,
    input  logic [15:0]    iv_pkt_bufadd_p0,
    output logic           o_pkt_ack_p0,
    input  logic [133:0]   iv_pkt_p1,
    input  logic           i_pkt_wr_p1,
    input  logic [15:0]    iv_pkt_bufadd_p1,
    output logic           o_pkt_ack_p1,
    output logic [133:0]   ov_pkt,
    output logic           o_pkt_wr,
    output logic [15:0]    ov_pkt_bufadd,
    input  logic           i_cnt_clear,
    output logic [15:0]    ov_wr_cnt_p0,
    output logic [15:0]    ov_wr_cnt_p1,
    output logic           o_conflict_pulse
);

    logic           rr_q, rr_d;
    logic           blind_p0_q, blind_p0_d;
    logic           blind_p1_q, blind_p1_d;
    logic [133:0]   pkt_q, pkt_d;
    logic [15:0]    bufadd_q, bufadd_d;
    logic           wr_q, wr_d;
    logic           ack_p0_q, ack_p0_d;
    logic           ack_p1_q, ack_p1_d;
    logic           conflict_q, conflict_d;
    logic [15:0]    cnt_p0_q, cnt_p0_d;
    logic [15:0]    cnt_p1_q, cnt_p1_d;

    logic elig_p0, elig_p1, grant_p0, grant_p1;

    always_comb begin
        // A port granted last cycle has its ack in flight and must not be re-granted yet.
        elig_p0  = i_pkt_wr_p0 & ~blind_p0_q;
        elig_p1  = i_pkt_wr_p1 & ~blind_p1_q;
        grant_p0 = elig_p0 & (~elig_p1 | (rr_q == 1'b0));
        grant_p1 = elig_p1 & (~elig_p0 | (rr_q == 1'b1));

        rr_d       = rr_q;
        pkt_d      = pkt_q;
        bufadd_d   = bufadd_q;
        if (grant_p0) begin
            rr_d     = 1'b1;
            pkt_d    = iv_pkt_p0;
            bufadd_d = iv_pkt_bufadd_p0;
        end else if (grant_p1) begin
            rr_d     = 1'b0;
            pkt_d    = iv_pkt_p1;
            bufadd_d = iv_pkt_bufadd_p1;
        end

        blind_p0_d = grant_p0;
        blind_p1_d = grant_p1;
        wr_d       = grant_p0 | grant_p1;
        ack_p0_d   = grant_p0;
        ack_p1_d   = grant_p1;
        conflict_d = elig_p0 & elig_p1;

        // Clear takes precedence over a coincident ack.
        if (i_cnt_clear) begin
            cnt_p0_d = 16'h0;
            cnt_p1_d = 16'h0;
        end else begin
            cnt_p0_d = cnt_p0_q + {15'h0, ack_p0_q};
            cnt_p1_d = cnt_p1_q + {15'h0, ack_p1_q};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rr_q       <= RR_INIT;
            blind_p0_q <= 1'b0;
            blind_p1_q <= 1'b0;
            pkt_q      <= 134'h0;
            bufadd_q   <= 16'h0;
            wr_q       <= 1'b0;
            ack_p0_q   <= 1'b0;
            ack_p1_q   <= 1'b0;
            conflict_q <= 1'b0;
            cnt_p0_q   <= 16'h0;
            cnt_p1_q   <= 16'h0;
        end else begin
            rr_q       <= rr_d;
            blind_p0_q <= blind_p0_d;
            blind_p1_q <= blind_p1_d;
            pkt_q      <= pkt_d;
            bufadd_q   <= bufadd_d;
            wr_q       <= wr_d;
            ack_p0_q   <= ack_p0_d;
            ack_p1_q   <= ack_p1_d;
            conflict_q <= conflict_d;
            cnt_p0_q   <= cnt_p0_d;
            cnt_p1_q   <= cnt_p1_d;
        end
    end

    assign ov_pkt           = pkt_q;
    assign ov_pkt_bufadd    = bufadd_q;
    assign o_pkt_wr         = wr_q;
    assign o_pkt_ack_p0     = ack_p0_q;
    assign o_pkt_ack_p1     = ack_p1_q;
    assign o_conflict_pulse = conflict_q;
    assign ov_wr_cnt_p0     = cnt_p0_q;
    assign ov_wr_cnt_p1     = cnt_p1_q;

endmodule
